// File: rtl/reg_bank_pkg.sv
// Shared types for the general-purpose register bank: operation codes and
// the carry/zero flag pair.
package reg_bank_pkg;

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_CLR  = 3'b001,
    OP_INC  = 3'b010,
    OP_DEC  = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_ROL  = 3'b110,
    OP_NOP  = 3'b111
  } wop_e;

  typedef struct packed {
    logic carry;
    logic zero;
  } flags_t;

endpackage

// File: rtl/reg_bank_alu.sv
// Combinational in-place operation unit: computes the next register value and
// carry from the old value; shared by the write path and the forwarding path.
module reg_bank_alu
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] old_val_i,
  input  logic [2:0]       wop_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] res_o,
  output logic             carry_o
);

  always_comb begin
    res_o   = old_val_i;
    carry_o = 1'b0;
    case (wop_e'(wop_i))
      OP_LOAD: res_o = wdata_i;
      OP_CLR:  res_o = '0;
      OP_INC: begin
        res_o   = old_val_i + WIDTH'(1);
        carry_o = &old_val_i;
      end
      OP_DEC: begin
        res_o   = old_val_i - WIDTH'(1);
        carry_o = ~|old_val_i;
      end
      OP_SHL: begin
        res_o   = {old_val_i[WIDTH-2:0], sin_i};
        carry_o = old_val_i[WIDTH-1];
      end
      OP_SHR: begin
        res_o   = {sin_i, old_val_i[WIDTH-1:1]};
        carry_o = old_val_i[0];
      end
      OP_ROL: begin
        res_o   = {old_val_i[WIDTH-2:0], old_val_i[WIDTH-1]};
        carry_o = old_val_i[WIDTH-1];
      end
      default: begin
        res_o   = old_val_i;
        carry_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/reg_bank.sv
// Bank of NUM_REGS x WIDTH registers with one in-place operation per cycle and
// two combinational read ports. Define REG_BANK_BYPASS_EN for write-through reads.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int NUM_REGS = 4,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [2:0]        wop,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              sin,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              carry,
  output logic              zero
);

  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  flags_t           flags_q;
  flags_t           flags_d;

  logic             exec;
  logic [WIDTH-1:0] old_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic [WIDTH-1:0] rd_a_raw;
  logic [WIDTH-1:0] rd_b_raw;

  // Reset is folded in so forwarding never leaks a value while the bank is held clear.
  assign exec = we && (wop != 3'(OP_NOP)) && (int'(waddr) < NUM_REGS) && !RST;

  always_comb begin
    old_w    = '0;
    rd_a_raw = '0;
    rd_b_raw = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (waddr == ADDR_W'(i))   old_w    = regs_q[i];
      if (raddr_a == ADDR_W'(i)) rd_a_raw = regs_q[i];
      if (raddr_b == ADDR_W'(i)) rd_b_raw = regs_q[i];
    end
  end

  reg_bank_alu #(.WIDTH(WIDTH)) u_alu (
    .old_val_i (old_w),
    .wop_i     (wop),
    .wdata_i   (wdata),
    .sin_i     (sin),
    .res_o     (alu_res),
    .carry_o   (alu_carry)
  );

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_next
    assign regs_d[gi] = (exec && (waddr == ADDR_W'(gi))) ? alu_res : regs_q[gi];
  end

  assign flags_d = '{carry: alu_carry, zero: (alu_res == '0)};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      flags_q <= '0;
    end else begin
      regs_q <= regs_d;
      if (exec) flags_q <= flags_d;
    end
  end

`ifdef REG_BANK_BYPASS_EN
  assign rdata_a = (exec && (raddr_a == waddr)) ? alu_res : rd_a_raw;
  assign rdata_b = (exec && (raddr_b == waddr)) ? alu_res : rd_b_raw;
`else
  assign rdata_a = rd_a_raw;
  assign rdata_b = rd_b_raw;
`endif

  assign carry = flags_q.carry;
  assign zero  = flags_q.zero;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios plus randomized ops
// against an arithmetic reference model; a 3-entry instance covers out-of-range access.
module tb_reg_bank;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic       we = 1'b0, sin = 1'b0;
  logic [1:0] waddr = '0, raddr_a = '0, raddr_b = '0;
  logic [2:0] wop = 3'b111;
  logic [7:0] wdata = '0, rdata_a, rdata_b;
  logic       carry, zero;

  logic       we3 = 1'b0, sin3 = 1'b0;
  logic [1:0] waddr3 = '0, raddr_a3 = '0, raddr_b3 = '0;
  logic [2:0] wop3 = 3'b111;
  logic [7:0] wdata3 = '0, rdata_a3, rdata_b3;
  logic       carry3, zero3;

  reg_bank #(.WIDTH(8), .NUM_REGS(4)) dut (
    .CLK(CLK), .RST(RST), .we(we), .waddr(waddr), .wop(wop), .wdata(wdata), .sin(sin),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .carry(carry), .zero(zero)
  );

  reg_bank #(.WIDTH(8), .NUM_REGS(3)) dut3 (
    .CLK(CLK), .RST(RST), .we(we3), .waddr(waddr3), .wop(wop3), .wdata(wdata3), .sin(sin3),
    .raddr_a(raddr_a3), .raddr_b(raddr_b3), .rdata_a(rdata_a3), .rdata_b(rdata_b3),
    .carry(carry3), .zero(zero3)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: register contents and flags as plain integers.
  int mem [4];
  int mc, mz;

  task automatic model_op(input int a, input int op, input int d, input int s);
    int v, r, c;
    v = mem[a];
    case (op)
      0: begin r = d;                      c = 0;               end
      1: begin r = 0;                      c = 0;               end
      2: begin r = (v + 1) % 256;          c = (v == 255);      end
      3: begin r = (v + 255) % 256;        c = (v == 0);        end
      4: begin r = (v * 2 + s) % 256;      c = v / 128;         end
      5: begin r = v / 2 + s * 128;        c = v % 2;           end
      6: begin r = (v * 2) % 256 + v / 128; c = v / 128;        end
      default: return;
    endcase
    mem[a] = r;
    mc     = c;
    mz     = (r == 0) ? 1 : 0;
  endtask

  task automatic do_op(input bit en, input int a, input int op, input int d, input int s);
    @(negedge CLK);
    we = en; waddr = 2'(a); wop = 3'(op); wdata = 8'(d); sin = s[0];
    @(posedge CLK);
    #1;
    we = 1'b0;
    if (en) model_op(a, op, d, s);
    $display("op we=%0d r%0d wop=%0d data=%02h sin=%0d -> model r=%02h c=%0d z=%0d",
             en, a, op, d, s, mem[a], mc, mz);
  endtask

  task automatic do_op3(input int a, input int op, input int d);
    @(negedge CLK);
    we3 = 1'b1; waddr3 = 2'(a); wop3 = 3'(op); wdata3 = 8'(d);
    @(posedge CLK);
    #1;
    we3 = 1'b0;
    $display("op3 r%0d wop=%0d data=%02h", a, op, d);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      raddr_a = 2'(i); raddr_b = 2'(3 - i);
      #1;
      total_cnt++;
      if (rdata_a !== 8'h00 || rdata_b !== 8'h00)
        $display("FAIL reset_read r%0d: got a=%02h b=%02h, want 00", i, rdata_a, rdata_b);
      else pass_cnt++;
    end
    total_cnt++;
    if (carry !== 1'b0 || zero !== 1'b0)
      $display("FAIL reset_flags: got c=%0d z=%0d, want 0 0", carry, zero);
    else pass_cnt++;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_load();
    do_op(1, 2, 0, 8'hA5, 0);
    raddr_a = 2'd2;
    #1;
    total_cnt++;
    if (rdata_a !== 8'(mem[2]) || carry !== 1'b0 || zero !== 1'b0)
      $display("FAIL load_r2: got %02h c=%0d z=%0d, want %02h c=0 z=0", rdata_a, carry, zero, mem[2]);
    else pass_cnt++;
  endtask

  task automatic test_inc_wrap();
    do_op(1, 1, 0, 8'hFF, 0);
    for (int k = 0; k < 2; k++) begin
      do_op(1, 1, 2, 0, 0);
      raddr_a = 2'd1;
      #1;
      total_cnt++;
      if (rdata_a !== 8'(mem[1]) || carry !== mc[0] || zero !== mz[0])
        $display("FAIL inc_wrap step%0d: got %02h c=%0d z=%0d, want %02h c=%0d z=%0d",
                 k, rdata_a, carry, zero, mem[1], mc, mz);
      else pass_cnt++;
    end
  endtask

  task automatic test_dec_wrap();
    do_op(1, 3, 1, 0, 0);
    do_op(1, 3, 3, 0, 0);
    raddr_b = 2'd3;
    #1;
    total_cnt++;
    if (rdata_b !== 8'hFF || carry !== 1'b1 || zero !== 1'b0)
      $display("FAIL dec_wrap: got %02h c=%0d z=%0d, want ff c=1 z=0", rdata_b, carry, zero);
    else pass_cnt++;
  endtask

  task automatic test_shifts();
    int ops [3] = '{4, 5, 6};
    int sins[3] = '{0, 1, 0};
    do_op(1, 0, 0, 8'h81, 0);
    for (int k = 0; k < 3; k++) begin
      do_op(1, 0, ops[k], 0, sins[k]);
      raddr_a = 2'd0;
      #1;
      total_cnt++;
      if (rdata_a !== 8'(mem[0]) || carry !== mc[0])
        $display("FAIL shift op%0d: got %02h c=%0d, want %02h c=%0d", ops[k], rdata_a, carry, mem[0], mc);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    do_op(1, 2, 0, 8'h7E, 0);
    @(negedge CLK);
    we = 1'b1; waddr = 2'd2; wop = 3'd2;
    @(posedge CLK);
    model_op(2, 2, 0, 0);
    @(posedge CLK);
    #1;
    we = 1'b0;
    model_op(2, 2, 0, 0);
    raddr_b = 2'd2;
    #1;
    total_cnt++;
    if (rdata_b !== 8'h80 || rdata_b !== 8'(mem[2]))
      $display("FAIL back_to_back_inc: got %02h, want 80", rdata_b);
    else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    int want;
    do_op(1, 1, 0, 8'h11, 0);
    @(negedge CLK);
    we = 1'b1; waddr = 2'd1; wop = 3'd0; wdata = 8'h3C; raddr_a = 2'd1; raddr_b = 2'd1;
    #1;
`ifdef REG_BANK_BYPASS_EN
    want = 8'h3C;
`else
    want = mem[1];
`endif
    total_cnt++;
    if (rdata_a !== 8'(want) || rdata_b !== 8'(want))
      $display("FAIL same_cycle_read: got a=%02h b=%02h, want %02h", rdata_a, rdata_b, want);
    else pass_cnt++;
    @(posedge CLK);
    #1;
    we = 1'b0;
    model_op(1, 0, 8'h3C, 0);
    total_cnt++;
    if (rdata_a !== 8'h3C || rdata_b !== 8'h3C)
      $display("FAIL same_cycle_after: got a=%02h b=%02h, want 3c", rdata_a, rdata_b);
    else pass_cnt++;
    // NOP with the strobe high must leave register and flags alone.
    do_op(1, 3, 1, 0, 0);
    do_op(1, 3, 7, 8'h99, 1);
    raddr_a = 2'd3;
    #1;
    total_cnt++;
    if (rdata_a !== 8'(mem[3]) || carry !== mc[0] || zero !== mz[0] || zero !== 1'b1)
      $display("FAIL nop_hold: got %02h c=%0d z=%0d, want %02h c=%0d z=1", rdata_a, carry, zero, mem[3], mc);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int a, op, d, s;
    bit en;
    for (int n = 0; n < 40; n++) begin
      a = $urandom_range(0, 3); op = $urandom_range(0, 7);
      d = $urandom_range(0, 255); s = $urandom_range(0, 1);
      en = ($urandom_range(0, 3) != 0);
      do_op(en, a, op, d, s);
      raddr_a = 2'($urandom_range(0, 3));
      raddr_b = 2'($urandom_range(0, 3));
      #1;
      total_cnt++;
      if (rdata_a !== 8'(mem[raddr_a]) || rdata_b !== 8'(mem[raddr_b]) ||
          carry !== mc[0] || zero !== mz[0])
        $display("FAIL random#%0d: got a=%02h b=%02h c=%0d z=%0d, want a=%02h b=%02h c=%0d z=%0d",
                 n, rdata_a, rdata_b, carry, zero, mem[raddr_a], mem[raddr_b], mc, mz);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_midrun();
    do_op(1, 1, 0, 8'h5A, 0);
    do_op(1, 2, 3, 0, 0);
    do_op(1, 2, 0, 8'hC3, 0);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    we = 1'b1; waddr = 2'd1; wop = 3'd0; wdata = 8'hEE; raddr_a = 2'd1; raddr_b = 2'd2;
    #1;
    total_cnt++;
    if (rdata_a !== 8'h00 || rdata_b !== 8'h00 || carry !== 1'b0 || zero !== 1'b0)
      $display("FAIL reset_async: got a=%02h b=%02h c=%0d z=%0d, want 0", rdata_a, rdata_b, carry, zero);
    else pass_cnt++;
    @(posedge CLK);
    #1;
    total_cnt++;
    if (rdata_a !== 8'h00 || zero !== 1'b0)
      $display("FAIL reset_discard: got a=%02h z=%0d, want 00 z=0", rdata_a, zero);
    else pass_cnt++;
    @(negedge CLK);
    we = 1'b0;
    RST = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = 0;
    mc = 0; mz = 0;
  endtask

  task automatic test_out_of_range();
    int want [3] = '{8'h55, 8'h00, 8'h12};
    do_op3(0, 0, 8'h55);
    do_op3(2, 0, 8'h12);
    do_op3(1, 0, 8'hFF);
    do_op3(1, 2, 0);
    @(negedge CLK);
    we3 = 1'b1; waddr3 = 2'd3; wop3 = 3'd0; wdata3 = 8'h77; raddr_b3 = 2'd3;
    #1;
    total_cnt++;
    if (rdata_b3 !== 8'h00)
      $display("FAIL oor_read_during_write: got %02h, want 00", rdata_b3);
    else pass_cnt++;
    @(posedge CLK);
    #1;
    we3 = 1'b0;
    $display("op3 r3 wop=0 data=77 (out of range)");
    total_cnt++;
    if (carry3 !== 1'b1 || zero3 !== 1'b1 || rdata_b3 !== 8'h00)
      $display("FAIL oor_flags: got c=%0d z=%0d b=%02h, want c=1 z=1 b=00", carry3, zero3, rdata_b3);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      raddr_a3 = 2'(i);
      #1;
      total_cnt++;
      if (rdata_a3 !== 8'(want[i]))
        $display("FAIL oor_hold r%0d: got %02h, want %02h", i, rdata_a3, want[i]);
      else pass_cnt++;
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 0;
    mc = 0; mz = 0;
    test_reset();
    test_load();
    test_inc_wrap();
    test_dec_wrap();
    test_shifts();
    test_back_to_back();
    test_same_cycle();
    test_random();
    test_reset_midrun();
    test_out_of_range();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
